// File: rtl/flowing_led_pkg.sv
// Shared constants for the flowing-LED controller: mode encodings, bounce/fill
// direction and the pattern loaded on reset or on a mode change.
package flowing_led_pkg;

  localparam logic [1:0] MODE_ROT_L  = 2'b00;
  localparam logic [1:0] MODE_ROT_R  = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_FILL   = 2'b11;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  // Wide enough for the largest legal LED bank; users slice to LED_W.
  localparam logic [63:0] LED_RESET_PAT = 64'd1;

endpackage

// File: rtl/led_tick_gen.sv
// Step-rate prescaler: one tick every step_div+1 enabled cycles, frozen while
// en is low, and cleared by clr (which also suppresses the tick).
module led_tick_gen #(
  parameter int DIV_W = 26
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] step_div,
  output logic             tick
);

  localparam logic [DIV_W-1:0] CNT_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0] CNT_ZERO = {DIV_W{1'b0}};

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic             hit_s;

  // step_div is compared live, so lowering it below cnt waits for the natural wrap.
  assign hit_s = (cnt_q == step_div);
  assign tick  = en & hit_s & ~clr;

  // Next prescaler count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = CNT_ZERO;
    end else if (en) begin
      if (hit_s) begin
        cnt_d = CNT_ZERO;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/flowing_led_ctrl.sv
// LED_W-wide flowing-LED controller: rotate-left/right, bounce and fill/drain
// patterns with a programmable step rate. Build option FLOWING_LED_ACTIVE_LOW_EN
// inverts the led port for common-anode boards.
module flowing_led_ctrl
  import flowing_led_pkg::*;
#(
  parameter int LED_W = 8,
  parameter int DIV_W = 26
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] step_div,
  output logic [LED_W-1:0] led,
  output logic             step,
  output logic             wrap
);

  localparam logic [LED_W-1:0] RST_PAT  = LED_RESET_PAT[LED_W-1:0];
  localparam logic [LED_W-1:0] ALL_ONES = {LED_W{1'b1}};

  logic [1:0]       mode_q;
  logic [1:0]       mode_d;
  logic [LED_W-1:0] led_q;
  logic [LED_W-1:0] led_d;
  dir_e             dir_q;
  dir_e             dir_d;
  logic             step_q;
  logic             step_d;
  logic             wrap_q;
  logic             wrap_d;

  logic             mode_chg_s;
  logic             tick_s;
  logic [LED_W-1:0] pat_nxt_s;
  dir_e             dir_nxt_s;

  assign mode_chg_s = (mode != mode_q);

  led_tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick_gen (
    .clk      (clk),
    .rstn     (rstn),
    .en       (en),
    .clr      (mode_chg_s),
    .step_div (step_div),
    .tick     (tick_s)
  );

  // Pattern and direction that a tick would produce in the current mode.
  always_comb begin
    pat_nxt_s = led_q;
    dir_nxt_s = dir_q;
    case (mode_q)
      MODE_ROT_L: begin
        pat_nxt_s = {led_q[LED_W-2:0], led_q[LED_W-1]};
      end
      MODE_ROT_R: begin
        pat_nxt_s = {led_q[0], led_q[LED_W-1:1]};
      end
      MODE_BOUNCE: begin
        if (dir_q == DIR_LEFT) begin
          pat_nxt_s = {led_q[LED_W-2:0], 1'b0};
          if (led_q[LED_W-2]) begin
            dir_nxt_s = DIR_RIGHT;
          end else begin
            dir_nxt_s = DIR_LEFT;
          end
        end else begin
          pat_nxt_s = {1'b0, led_q[LED_W-1:1]};
          if ({1'b0, led_q[LED_W-1:1]} == RST_PAT) begin
            dir_nxt_s = DIR_LEFT;
          end else begin
            dir_nxt_s = DIR_RIGHT;
          end
        end
      end
      MODE_FILL: begin
        if (dir_q == DIR_LEFT) begin
          pat_nxt_s = {led_q[LED_W-2:0], 1'b1};
          if ({led_q[LED_W-2:0], 1'b1} == ALL_ONES) begin
            dir_nxt_s = DIR_RIGHT;
          end else begin
            dir_nxt_s = DIR_LEFT;
          end
        end else begin
          pat_nxt_s = {1'b0, led_q[LED_W-1:1]};
          if ({1'b0, led_q[LED_W-1:1]} == RST_PAT) begin
            dir_nxt_s = DIR_LEFT;
          end else begin
            dir_nxt_s = DIR_RIGHT;
          end
        end
      end
      default: begin
        pat_nxt_s = led_q;
        dir_nxt_s = dir_q;
      end
    endcase
  end

  // Next state: a mode change reloads and wins over a coincident tick.
  always_comb begin
    mode_d = mode;
    led_d  = led_q;
    dir_d  = dir_q;
    step_d = 1'b0;
    wrap_d = 1'b0;
    if (mode_chg_s) begin
      led_d = RST_PAT;
      dir_d = DIR_LEFT;
    end else if (tick_s) begin
      led_d  = pat_nxt_s;
      dir_d  = dir_nxt_s;
      step_d = 1'b1;
      wrap_d = (pat_nxt_s == RST_PAT);
    end else begin
      led_d = led_q;
      dir_d = dir_q;
    end
  end

  // Pattern, direction and strobe registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q <= MODE_ROT_L;
      led_q  <= RST_PAT;
      dir_q  <= DIR_LEFT;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      led_q  <= led_d;
      dir_q  <= dir_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
    end
  end

`ifdef FLOWING_LED_ACTIVE_LOW_EN
  assign led = ~led_q;
`else
  assign led = led_q;
`endif
  assign step = step_q;
  assign wrap = wrap_q;

endmodule

// File: doc/flowing_led_ctrl.md
Name: flowing_led_ctrl

Overview:
Parametrised successor to the 8-bit flowing-LED block. Drives an LED_W-wide LED bank with four run-time selectable patterns: rotate-left, rotate-right, bounce and fill/drain. The step rate is programmable through an internal prescaler. Sits between the board clock/reset and the LED pins, and exports step/wrap strobes for status logic.

Parameters:
LED_W, 8, number of LEDs; legal range 2..64
DIV_W, 26, width of the prescaler counter and of step_div

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous, active-low reset
en  input  1  1 = pattern advances; 0 = freeze (prescaler holds, led holds)
mode  input  2  00 rotate-left, 01 rotate-right, 10 bounce, 11 fill/drain
step_div  input  DIV_W  steps occur every step_div+1 clk cycles
led  output  LED_W  LED drive pattern (registered)
step  output  1  one-cycle pulse coincident with each led update
wrap  output  1  one-cycle pulse when a step makes led == 1 (LSB only)

Behaviour:
- Reset (rstn low, async): led = 1 (bit0 lit), prescaler cnt = 0, dir = LEFT, mode_q = 00, step = 0, wrap = 0.
- Prescaler: when en = 1 and cnt == step_div, a tick occurs and cnt -> 0. Otherwise cnt -> cnt+1 while en = 1, and holds while en = 0. step_div = 0 gives a tick every cycle.
- step_div is sampled live. If it is lowered below cnt, the next tick occurs on the cnt wrap at 2^DIV_W (no early clamp).
- On a tick, led updates on the same clock edge, step = 1 for that cycle, and wrap = 1 if the new led == 1. Latency from tick condition to new led: 1 clk.
- Rotate-left: led <= {led[LED_W-2:0], led[LED_W-1]}. Period LED_W steps.
- Rotate-right: led <= {led[0], led[LED_W-1:1]}. From 1 the next value is the MSB only.
- Bounce, 2-state FSM (LEFT/RIGHT):
  - LEFT: shift left; when the new led has the MSB set -> RIGHT.
  - RIGHT: shift right; when the new led == 1 -> LEFT.
  - The end positions are never repeated. Period 2*LED_W-2 steps.
- Fill/drain, same FSM:
  - LEFT: led <= {led[LED_W-2:0],1'b1}; on all-ones -> RIGHT.
  - RIGHT: led <= {1'b0, led[LED_W-1:1]}; on 1 -> LEFT.
  - Sequence for LED_W=4: 1,3,7,F,7,3,1,3... Period 2*LED_W-2.
- Mode change: mode is registered into mode_q every cycle. When mode != mode_q, the next edge reloads led = 1, cnt = 0 and dir = LEFT, with no step and no wrap. This reload takes priority over a coincident tick.
- Illegal/corrupt led (e.g. 0) is not recovered automatically; only reset or a mode change restores it. Reachable states never contain 0.
- en deasserted mid-count: state is frozen exactly, and counting resumes from the frozen cnt.

Optional Feature:
Macro FLOWING_LED_ACTIVE_LOW_EN.
- Defined: the led port is the bitwise inverse of the internal pattern (common-anode boards). Reset drives led = ~1. step and wrap are unchanged.
- Undefined: led is the internal pattern, active-high.

Decomposition:
- Package flowing_led_pkg:
  - mode constants MODE_ROT_L = 2'b00, MODE_ROT_R = 2'b01, MODE_BOUNCE = 2'b10, MODE_FILL = 2'b11
  - direction constants DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1
  - reset pattern constant
- Sub-module led_tick_gen: parameter DIV_W; ports clk, rstn, en, clr, step_div, tick. It holds the prescaler.
- The pattern register and FSM stay in flowing_led_ctrl.

Test Plan:
1. LED_W=8, mode=00, step_div=3, en=1 after reset release -> led 01,02,04...80,01 with steps every 4 clk; wrap pulses exactly once, on the 80->01 step.
2. mode=01, step_div=0 -> led 01,80,40,20,...,02,01 on consecutive cycles; wrap on the 02->01 step.
3. mode=10, step_div=0 -> 01,02,...,80,40,...,02,01,02; 80 and 01 each appear once per 14-step period; wrap on every return to 01.
4. mode=11, LED_W=4, step_div=1 -> 1,3,7,F,7,3,1 at 2-clk spacing; switch mode to 00 mid-sequence -> led = 1 one edge later with no step pulse, then rotation resumes after 2 clk.
5. en dropped for 10 clk at cnt=2 (step_div=5) -> led, cnt, step all frozen; the next step occurs 3 clk after en returns.
6. Assert rstn low asynchronously mid-cycle during bounce RIGHT -> led = 01 immediately, without waiting for a clk edge; after release, direction is LEFT. Repeat with FLOWING_LED_ACTIVE_LOW_EN defined -> led = FE at reset, and the pattern is inverted thereafter.
